// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (fetch / load-store) arbiter for one single-ported memory bus
// Optional bus-wait timeout: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_done,
  output logic                mem_busy,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t state, state_nxt;
  logic   gnt, last, grant_d, timeout;

  `ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       timed_out;

  // Counter reaches the limit on the edge ending the TIMEOUT_CYCLES-th unacked BUS cycle.
  assign timeout = (state == BUS) && !m_ack && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign err     = (state == RESP) && timed_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == BUS) begin
        wait_cnt  <= wait_cnt + 8'd1;
        timed_out <= timeout;
      end else begin
        wait_cnt  <= '0;
      end
    end
  end
  `else
  assign timeout = 1'b0;
  assign err     = 1'b0;
  `endif

  always_comb begin
    state_nxt = state;
    grant_d   = OWN_I;
    case (state)
      IDLE: begin
        if (if_req && ls_req) begin
          grant_d   = (last == OWN_I) ? OWN_D : OWN_I;
          state_nxt = BUS;
        end else if (ls_req) begin
          grant_d   = OWN_D;
          state_nxt = BUS;
        end else if (if_req) begin
          state_nxt = BUS;
        end
      end
      BUS:     if (m_ack || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt      <= OWN_I;
      last     <= OWN_I;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
      if_rdata <= '0;
      ls_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (state_nxt == BUS) begin
          gnt   <= grant_d;
          m_req <= 1'b1;
          if (grant_d == OWN_D) begin
            m_we    <= ls_we;
            m_addr  <= ls_addr;
            m_wdata <= ls_wdata;
            m_be    <= ls_be;
          end else begin
            m_we    <= 1'b0;
            m_addr  <= if_addr;
            m_wdata <= '0;
            m_be    <= '1;
          end
        end
        BUS: if (state_nxt == RESP) begin
          m_req <= 1'b0;
          last  <= gnt;
          // Ack wins over timeout because timeout is already gated by !m_ack.
          if (gnt == OWN_I) begin
            if_rdata <= timeout ? '0 : m_rdata;
          end else if (timeout) begin
            ls_rdata <= '0;
          end else if (!m_we) begin
            ls_rdata <= m_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_done  = (state == RESP) && (gnt == OWN_I);
  assign ls_done  = (state == RESP) && (gnt == OWN_D);
  assign mem_busy = ls_req && !((state == RESP) && (gnt == OWN_D));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, ls_req, ls_we, m_ack;
  logic [31:0] if_addr, ls_addr, ls_wdata, m_rdata;
  logic [3:0]  ls_be;
  logic [31:0] if_rdata, ls_rdata, m_addr, m_wdata;
  logic        if_done, ls_done, mem_busy, m_req, m_we, err;
  logic [3:0]  m_be;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_rdata(ls_rdata), .ls_done(ls_done), .mem_busy(mem_busy),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic        ls_req;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        e_m_req;
    logic        e_if_done;
    logic        e_ls_done;
    logic        e_busy;
    logic [31:0] e_if_rdata;
    logic [31:0] e_ls_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; m_ack = 1'b0;
    m_rdata = '0; ls_wdata = '0; ls_be = '0;
    if_addr = 32'h100; ls_addr = 32'h2000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_mreq(input string name);
    int k = 0;
    @(negedge clk); #2;
    while (!m_req && k < 20) begin
      @(negedge clk); #2;
      k++;
    end
    check(name, 32'(m_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ngr;
    logic prev_done, done_now;

    // if_req ls_req ack rdata | m_req if_done ls_done busy if_rdata ls_rdata
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'hCAFE0001, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'hCAFE0001};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'hCAFE0001};

    do_reset();
    #2;
    check("rst_m_req",    32'(m_req),   32'd0);
    check("rst_if_done",  32'(if_done), 32'd0);
    check("rst_ls_done",  32'(ls_done), 32'd0);
    check("rst_err",      32'(err),     32'd0);
    check("rst_m_addr",   m_addr,       32'h0);
    check("rst_m_be",     32'(m_be),    32'h0);
    check("rst_if_rdata", if_rdata,     32'h0);
    check("rst_ls_rdata", ls_rdata,     32'h0);

    // Fetch with same-cycle ack, then a load acked 3 cycles after m_req
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if_req  = vecs[i].if_req;
      ls_req  = vecs[i].ls_req;
      m_ack   = vecs[i].m_ack;
      m_rdata = vecs[i].m_rdata;
      #2;
      check($sformatf("vec%0d_m_req", i),    32'(m_req),    32'(vecs[i].e_m_req));
      check($sformatf("vec%0d_if_done", i),  32'(if_done),  32'(vecs[i].e_if_done));
      check($sformatf("vec%0d_ls_done", i),  32'(ls_done),  32'(vecs[i].e_ls_done));
      check($sformatf("vec%0d_mem_busy", i), 32'(mem_busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_if_rdata", i), if_rdata,      vecs[i].e_if_rdata);
      check($sformatf("vec%0d_ls_rdata", i), ls_rdata,      vecs[i].e_ls_rdata);
      check($sformatf("vec%0d_err", i),      32'(err),      32'd0);
      if (i == 1) begin
        check("fetch_m_addr", m_addr,     32'h100);
        check("fetch_m_we",   32'(m_we),  32'd0);
        check("fetch_m_be",   32'(m_be),  32'hF);
      end
      if (i == 5) check("load_m_addr", m_addr, 32'h2000);
    end

    // Store: fields latched at grant and held while ack is withheld 5 cycles
    @(negedge clk);
    ls_we = 1'b1; ls_addr = 32'h3000; ls_wdata = 32'h1234; ls_be = 4'h3; ls_req = 1'b1;
    wait_mreq("store_grant");
    ls_we = 1'b0; ls_addr = 32'h4444; ls_wdata = 32'hFFFFFFFF; ls_be = 4'hC;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) begin
        @(negedge clk); #2;
      end
      check($sformatf("store_m_req_%0d", j),   32'(m_req), 32'd1);
      check($sformatf("store_m_we_%0d", j),    32'(m_we),  32'd1);
      check($sformatf("store_m_be_%0d", j),    32'(m_be),  32'h3);
      check($sformatf("store_m_wdata_%0d", j), m_wdata,    32'h1234);
      check($sformatf("store_m_addr_%0d", j),  m_addr,     32'h3000);
    end
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
    #2;
    check("store_ack_cycle_ls_done", 32'(ls_done), 32'd0);
    @(negedge clk);
    m_ack = 1'b0;
    #2;
    check("store_ls_done",  32'(ls_done), 32'd1);
    check("store_ls_rdata", ls_rdata,     32'hCAFE0001);
    check("store_m_req",    32'(m_req),   32'd0);
    @(negedge clk);
    ls_req = 1'b0;
    #2;
    check("store_done_pulse", 32'(ls_done), 32'd0);

    // Both requests held: grants must alternate D, I, D, I with a dead cycle after each done
    do_reset();
    if_req = 1'b1; ls_req = 1'b1;
    ngr = 0;
    prev_done = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      m_ack = 1'b0;
      #2;
      done_now = if_done | ls_done;
      check($sformatf("alt_both_done_%0d", c), 32'(if_done & ls_done), 32'd0);
      if (done_now) check($sformatf("alt_resp_m_req_%0d", c), 32'(m_req), 32'd0);
      if (prev_done) begin
        check($sformatf("alt_done_width_%0d", c), 32'(done_now), 32'd0);
        check($sformatf("alt_dead_cycle_%0d", c), 32'(m_req), 32'd0);
      end
      if (m_req) begin
        if (ngr < 4)
          check($sformatf("alt_grant_%0d", ngr), m_addr, (ngr % 2 == 0) ? 32'h2000 : 32'h100);
        ngr++;
        m_ack = 1'b1;
        m_rdata = 32'(c);
      end
      prev_done = done_now;
    end
    check("alt_grant_count", 32'(ngr >= 4), 32'd1);

    // Reset two cycles into BUS drops m_req at once; still-high request is re-granted
    do_reset();
    ls_we = 1'b0; ls_addr = 32'h2000; ls_req = 1'b1;
    wait_mreq("rst_mid_grant");
    @(negedge clk); #2;
    check("rst_mid_in_bus", 32'(m_req), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_m_req_drop", 32'(m_req),   32'd0);
    check("rst_mid_ls_done",    32'(ls_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    check("rst_mid_idle", 32'(m_req), 32'd0);
    @(negedge clk); #2;
    check("rst_mid_regrant", 32'(m_req), 32'd1);
    check("rst_mid_addr",    m_addr,     32'h2000);
    m_ack = 1'b1; m_rdata = 32'h5555AAAA;
    @(negedge clk);
    m_ack = 1'b0;
    #2;
    check("rst_mid_ls_done",  32'(ls_done), 32'd1);
    check("rst_mid_ls_rdata", ls_rdata,     32'h5555AAAA);
    @(negedge clk);
    ls_req = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // No ack: after 4 BUS cycles done and err pulse together with rdata forced to 0
    @(negedge clk);
    ls_req = 1'b1;
    wait_mreq("to_grant");
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin
        @(negedge clk); #2;
      end
      check($sformatf("to_bus_%0d", j), 32'(m_req), 32'd1);
    end
    @(negedge clk); #2;
    check("to_ls_done",  32'(ls_done), 32'd1);
    check("to_err",      32'(err),     32'd1);
    check("to_ls_rdata", ls_rdata,     32'h0);
    check("to_m_req",    32'(m_req),   32'd0);
    @(negedge clk);
    ls_req = 1'b0;
    // Ack on the 4th BUS cycle wins over the limit
    @(negedge clk);
    ls_req = 1'b1;
    wait_mreq("to2_grant");
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      if (j == 3) begin
        m_ack = 1'b1;
        m_rdata = 32'h00000077;
      end
      #2;
    end
    @(negedge clk);
    m_ack = 1'b0;
    #2;
    check("to2_ls_done",  32'(ls_done), 32'd1);
    check("to2_err",      32'(err),     32'd0);
    check("to2_ls_rdata", ls_rdata,     32'h00000077);
    @(negedge clk);
    ls_req = 1'b0;
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-ported memory bus between instruction fetch and load/store. Sits between the core control FSM and the memory. Serialises one transaction at a time with a req/ack handshake to memory and a level-req / pulse-done handshake to each requester. Generates the `mem_busy` flag that holds the control FSM in MEM_WAIT.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; must be a multiple of 8
- `TIMEOUT_CYCLES`, 255, bus-wait limit, 1..255; used only with `MEM_ARB_TIMEOUT_EN`

Ports:
- `clk` in 1: clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `if_req` in 1: fetch request, level, held until `if_done`
- `if_addr` in ADDR_W: fetch address
- `if_rdata` out DATA_W: fetched word, valid when `if_done`=1
- `if_done` out 1: one-cycle completion pulse to fetch
- `ls_req` in 1: load/store request, level, held until `ls_done`
- `ls_we` in 1: 1=store, 0=load
- `ls_addr` in ADDR_W: load/store address
- `ls_wdata` in DATA_W: store data
- `ls_be` in DATA_W/8: store byte enables
- `ls_rdata` out DATA_W: load data, valid when `ls_done`=1
- `ls_done` out 1: one-cycle completion pulse to load/store
- `mem_busy` out 1: to control FSM; data access pending
- `m_req` out 1: memory request
- `m_we`, `m_addr`, `m_wdata`, `m_be` out: memory command fields
- `m_ack` in 1: memory completion, one cycle
- `m_rdata` in DATA_W: read data, valid with `m_ack`
- `err` out 1: timeout pulse, coincident with `done`

## Operation
States: IDLE, BUS, RESP. Register `gnt` records the owner, I or D. Register `last` records the previous owner.
- **IDLE**
  - If exactly one request is high, grant it.
  - If both are high, grant the owner opposite `last`.
  - On grant: latch the requester's command fields into the `m_*` registers, set `gnt`, set `m_req`=1, go to BUS.
  - Fetch commands drive `m_we`=0 and `m_be`=all-ones.
- **BUS**
  - Hold `m_req` and all `m_*` fields stable.
  - On `m_ack`: capture `m_rdata` into the owner's rdata register (loads and fetches only; stores leave it unchanged), clear `m_req`, assert the owner's done, update `last`=`gnt`, go to RESP.
- **RESP**
  - Done is high for exactly this cycle. Next state is always IDLE.
  - The requester drops req on the edge ending RESP, so IDLE never re-grants a completed request.
- `mem_busy` = `ls_req` & ~(state==RESP & `gnt`==D), combinational.
- `m_ack` is ignored outside BUS.
- Requester command inputs are sampled only at grant. Later changes have no effect on the transaction.

## Timing
- Reset values: state IDLE, `last`=I (so the first tie grants D), `m_req`=0, all `m_*` fields 0, `if_done`/`ls_done`/`err`=0, `if_rdata`/`ls_rdata`=0.
- Reset is asynchronous. Asserting `reset_n` mid-transaction drops `m_req` immediately and abandons the memory access; the memory must tolerate this.
- Latency, counted from the first cycle req is high while in IDLE (cycle 0):
  - `m_req` rises in cycle 1.
  - With `m_ack` in cycle 1+k, done is high in cycle 2+k.
  - Minimum is 2 cycles (k=0).
- Back-to-back: IDLE follows RESP, so there is at least one dead cycle between transactions. Maximum throughput is one transaction per 3 cycles.
- Simultaneous requests alternate strictly, so neither requester can be starved.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering BUS and increments each BUS cycle without `m_ack`.
  - When it reaches `TIMEOUT_CYCLES`, the block clears `m_req`, goes to RESP, pulses the owner's done together with `err`, and loads the owner's rdata with 0.
  - `m_ack` in the same cycle as the limit takes precedence, and the transaction completes normally.
- Not defined: BUS waits indefinitely, the counter is absent, and `err` is tied to 0.

## Test plan
- Fetch, `if_addr`=0x100, memory acks in the same cycle as `m_req` with 0xDEADBEEF: `m_req` rises at cycle 1; `if_done`=1 with `if_rdata`=0xDEADBEEF at cycle 2; `m_be`=0xF, `m_we`=0.
- Load, `ls_addr`=0x2000, ack 3 cycles after `m_req`: `mem_busy`=1 from cycle 0 through cycle 4, 0 in cycle 5; `ls_done` high in cycle 5 only; `ls_rdata` captured.
- Store, `ls_be`=0x3, `ls_wdata`=0x1234: `m_we`=1, `m_be`=0x3, and fields stay stable while the ack is withheld 5 cycles; `ls_rdata` is unchanged after completion.
- `if_req` and `ls_req` held high continuously after reset: grants go D, I, D, I; each done is one cycle; no grant in any RESP cycle.
- Drop `reset_n` two cycles into BUS: `m_req`=0 immediately; after release the block is in IDLE and re-grants the still-high request normally.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack: done and `err` pulse together, rdata=0. A second run with ack on the 4th BUS cycle completes normally with `err`=0.
